multi_tick_generator: RTL and testbench

Parametrised, multi-channel tick source for the timer/stopwatch datapath. Each of N_CH channels owns a programmable-period counter in one of two modes. In periodic mode it free-runs. In one-shot mode it fires once, then idles. Each channel emits a registered one-cycle tick pulse consumed by the display, timebase and alarm logic.

---
 rtl/multi_tick_generator.sv | 204 ++++++++++++++++++++
 tb/tb_multi_tick_generator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_generator.sv
// ---------------------------------------------------------------------------
// multi_tick_generator
// Multi-channel programmable tick source. Each channel counts 0..P and emits
// a registered one-cycle tick when it reaches its active period P, so ticks
// are P+1 cycles apart. A channel is either periodic (free-running) or
// one-shot (fires once, then idles).
//
// Every channel keeps two copies of its configuration:
//   - the shadow copy, which is written by the config port at any time;
//   - the active copy, which the counter actually uses.
// The active copy is refreshed from the shadow only on a start and on a
// terminal count. This means a config write never disturbs an interval that
// is already in progress.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_cfg_we       config write strobe
//   i_cfg_ch       channel addressed by the config write (out-of-range ignored)
//   i_cfg_period   period P (tick interval is P+1 cycles)
//   i_cfg_oneshot  1 = one-shot mode, 0 = periodic mode
//   i_start        per-channel start/restart strobe
//   i_stop         per-channel stop strobe (wins over start and terminal)
//   o_tick         per-channel registered one-cycle tick pulse
//   o_busy         per-channel registered RUN indicator
//   o_tick_any     registered OR of all tick terms, aligned with o_tick
// ---------------------------------------------------------------------------
module multi_tick_generator #(
    parameter int                CNT_W          = 20,
    parameter int                N_CH           = 4,
    parameter int                CH_W           = 2,
    parameter logic [CNT_W-1:0]  DEFAULT_PERIOD = 20'd99999,
    parameter logic [N_CH-1:0]   AUTOSTART      = 4'b0001
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [CNT_W-1:0]  i_cfg_period,
    input  logic              i_cfg_oneshot,
    input  logic [N_CH-1:0]   i_start,
    input  logic [N_CH-1:0]   i_stop,
    output logic [N_CH-1:0]   o_tick,
    output logic [N_CH-1:0]   o_busy,
    output logic              o_tick_any
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // The channel count is held one bit wider than the select field. This
    // lets the range check also cover the case N_CH == 2**CH_W.
    localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

    state_t             state_r     [N_CH];
    state_t             state_nxt_s [N_CH];
    logic [CNT_W-1:0]   count_r     [N_CH];
    logic [CNT_W-1:0]   count_nxt_s [N_CH];
    logic [CNT_W-1:0]   act_p_r     [N_CH];
    logic [CNT_W-1:0]   act_p_nxt_s [N_CH];
    logic [CNT_W-1:0]   shd_p_r     [N_CH];
    logic [N_CH-1:0]    act_os_r;
    logic [N_CH-1:0]    act_os_nxt_s;
    logic [N_CH-1:0]    shd_os_r;
    logic [N_CH-1:0]    cfg_sel_s;
    logic               cfg_in_range_s;
    logic [N_CH-1:0]    term_s;
    logic [N_CH-1:0]    tick_nxt_s;
    logic [N_CH-1:0]    busy_nxt_s;
    logic               tick_any_nxt_s;
    logic [N_CH-1:0]    tick_r;
    logic [N_CH-1:0]    busy_r;
    logic               tick_any_r;

    // Decode which channel (if any) the config write addresses.
    always_comb begin
        cfg_in_range_s = ({1'b0, i_cfg_ch} < N_CH_L);
        cfg_sel_s      = {N_CH{1'b0}};
        for (int ch = 0; ch < N_CH; ch++) begin
            if (i_cfg_we && cfg_in_range_s && (i_cfg_ch == CH_W'(ch))) begin
                cfg_sel_s[ch] = 1'b1;
            end else begin
                cfg_sel_s[ch] = 1'b0;
            end
        end
    end

    // Shadow configuration registers, written by the config port.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                shd_p_r[ch] <= DEFAULT_PERIOD;
            end
            shd_os_r <= {N_CH{1'b0}};
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (cfg_sel_s[ch]) begin
                    shd_p_r[ch]  <= i_cfg_period;
                    shd_os_r[ch] <= i_cfg_oneshot;
                end
            end
        end
    end

    // Per-channel next state, counter and active-config reload.
    // The shadow is read before the edge, so a write in the same cycle only
    // takes effect from the following reload.
    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            state_nxt_s[ch]  = state_r[ch];
            count_nxt_s[ch]  = count_r[ch];
            act_p_nxt_s[ch]  = act_p_r[ch];
            act_os_nxt_s[ch] = act_os_r[ch];
            term_s[ch]       = 1'b0;
            if (i_stop[ch]) begin
                state_nxt_s[ch] = ST_IDLE;
                count_nxt_s[ch] = {CNT_W{1'b0}};
            end else if (i_start[ch]) begin
                // A restart also suppresses a tick on a terminal cycle.
                state_nxt_s[ch]  = ST_RUN;
                count_nxt_s[ch]  = {CNT_W{1'b0}};
                act_p_nxt_s[ch]  = shd_p_r[ch];
                act_os_nxt_s[ch] = shd_os_r[ch];
            end else begin
                case (state_r[ch])
                    ST_IDLE: begin
                        count_nxt_s[ch] = {CNT_W{1'b0}};
                    end
                    ST_RUN: begin
                        if (count_r[ch] == act_p_r[ch]) begin
                            term_s[ch]       = 1'b1;
                            count_nxt_s[ch]  = {CNT_W{1'b0}};
                            act_p_nxt_s[ch]  = shd_p_r[ch];
                            act_os_nxt_s[ch] = shd_os_r[ch];
                            // The mode that was active during this interval
                            // decides whether the channel keeps running.
                            state_nxt_s[ch]  = act_os_r[ch] ? ST_IDLE : ST_RUN;
                        end else begin
                            count_nxt_s[ch] = count_r[ch] + CNT_W'(1'b1);
                        end
                    end
                    default: begin
                        state_nxt_s[ch] = ST_IDLE;
                        count_nxt_s[ch] = {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Output terms. These are computed from the next state so that the
    // registered outputs line up with the edge that caused them.
    always_comb begin
        tick_nxt_s = term_s;
        busy_nxt_s = {N_CH{1'b0}};
        for (int ch = 0; ch < N_CH; ch++) begin
            if (state_nxt_s[ch] == ST_RUN) begin
                busy_nxt_s[ch] = 1'b1;
            end else begin
                busy_nxt_s[ch] = 1'b0;
            end
        end
        tick_any_nxt_s = |term_s;
    end

    // Channel state, counter and active configuration registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_r[ch] <= AUTOSTART[ch] ? ST_RUN : ST_IDLE;
                count_r[ch] <= {CNT_W{1'b0}};
                act_p_r[ch] <= DEFAULT_PERIOD;
            end
            act_os_r <= {N_CH{1'b0}};
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                state_r[ch] <= state_nxt_s[ch];
                count_r[ch] <= count_nxt_s[ch];
                act_p_r[ch] <= act_p_nxt_s[ch];
            end
            act_os_r <= act_os_nxt_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_r     <= {N_CH{1'b0}};
            busy_r     <= AUTOSTART;
            tick_any_r <= 1'b0;
        end else begin
            tick_r     <= tick_nxt_s;
            busy_r     <= busy_nxt_s;
            tick_any_r <= tick_any_nxt_s;
        end
    end

    assign o_tick     = tick_r;
    assign o_busy     = busy_r;
    assign o_tick_any = tick_any_r;

endmodule

// File: tb/tb_multi_tick_generator.sv
module tb_multi_tick_generator;

    localparam int             CNT_W = 8;
    localparam int             N     = 4;
    localparam int             CH_W  = 3;
    localparam logic [7:0]     DEF_P = 8'd4;
    localparam logic [3:0]     AUTO  = 4'b0001;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = 3'd0;
    logic [CNT_W-1:0]  cfg_period = 8'd0;
    logic              cfg_oneshot = 1'b0;
    logic [N-1:0]      start = 4'd0;
    logic [N-1:0]      stop = 4'd0;
    logic [N-1:0]      tick;
    logic [N-1:0]      busy;
    logic              tick_any;

    int errors = 0;
    int checks = 0;

    multi_tick_generator #(
        .CNT_W(CNT_W), .N_CH(N), .CH_W(CH_W),
        .DEFAULT_PERIOD(DEF_P), .AUTOSTART(AUTO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
        .i_cfg_period(cfg_period), .i_cfg_oneshot(cfg_oneshot),
        .i_start(start), .i_stop(stop),
        .o_tick(tick), .o_busy(busy), .o_tick_any(tick_any)
    );

    always #5 clk = ~clk;

    // Reference model: each channel keeps the absolute cycle of its next
    // tick. The model does not keep a counter.
    typedef struct {
        logic [N-1:0] tick;
        logic [N-1:0] busy;
        logic         any;
    } exp_t;

    exp_t exp_q[$];
    int   m_cyc;
    bit   m_run  [N];
    bit   m_os   [N];
    int   m_next [N];
    int   m_shp  [N];
    bit   m_shos [N];
    exp_t m_e;
    exp_t mon_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0;
            for (int c = 0; c < N; c++) begin
                m_run[c]  = AUTO[c];
                m_os[c]   = 1'b0;
                m_shp[c]  = int'(DEF_P);
                m_shos[c] = 1'b0;
                m_next[c] = int'(DEF_P) + 1;
            end
            exp_q.delete();
        end else begin
            m_cyc++;
            m_e.tick = '0;
            for (int c = 0; c < N; c++) begin
                if (stop[c]) begin
                    m_run[c] = 1'b0;
                end else if (start[c]) begin
                    m_run[c]  = 1'b1;
                    m_os[c]   = m_shos[c];
                    m_next[c] = m_cyc + m_shp[c] + 1;
                end else if (m_run[c] && m_cyc == m_next[c]) begin
                    m_e.tick[c] = 1'b1;
                    if (m_os[c]) m_run[c] = 1'b0;
                    else         m_next[c] = m_cyc + m_shp[c] + 1;
                    m_os[c] = m_shos[c];
                end
            end
            if (cfg_we && int'(cfg_ch) < N) begin
                m_shp[cfg_ch]  = int'(cfg_period);
                m_shos[cfg_ch] = cfg_oneshot;
            end
            for (int c = 0; c < N; c++) m_e.busy[c] = m_run[c];
            m_e.any = |m_e.tick;
            exp_q.push_back(m_e);
        end
    end

    // Monitor: after each edge, take the oldest expectation and compare it
    // with what the DUT is presenting.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (tick !== mon_e.tick) begin
                errors++;
                $display("FAIL tick cyc=%0d got=%b exp=%b", m_cyc, tick, mon_e.tick);
            end
            checks++;
            if (busy !== mon_e.busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", m_cyc, busy, mon_e.busy);
            end
            checks++;
            if (tick_any !== mon_e.any) begin
                errors++;
                $display("FAIL tick_any cyc=%0d got=%b exp=%b", m_cyc, tick_any, mon_e.any);
            end
        end
    end

    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, expv);
        end
    endtask

    task automatic step(input logic we, input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] p,
                        input logic os, input logic [N-1:0] st, input logic [N-1:0] sp);
        @(negedge clk);
        cfg_we = we; cfg_ch = ch; cfg_period = p; cfg_oneshot = os;
        start = st; stop = sp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'd0, 1'b0, 4'd0, 4'd0);
    endtask

    initial begin
        bit found;
        logic [N-1:0] rs, rp;
        // Reset state, checked while reset is held.
        repeat (3) @(negedge clk);
        check_now("rst_tick", 32'(tick), 32'd0);
        check_now("rst_busy", 32'(busy), 32'(AUTO));
        check_now("rst_any", 32'(tick_any), 32'd0);
        rst_n = 1'b1;
        idle(12);

        // ch1 periodic with P=2.
        step(1'b1, 3'd1, 8'd2, 1'b0, 4'd0, 4'd0);
        step(1'b0, 3'd0, 8'd0, 1'b0, 4'b0010, 4'd0);
        idle(12);

        // ch2 one-shot with P=3, followed by a long quiet window.
        step(1'b1, 3'd2, 8'd3, 1'b1, 4'd0, 4'd0);
        step(1'b0, 3'd0, 8'd0, 1'b0, 4'b0100, 4'd0);
        idle(24);

        // Period change while ch1 is mid-interval; then an out-of-range write.
        step(1'b1, 3'd1, 8'd5, 1'b0, 4'd0, 4'd0);
        idle(20);
        step(1'b1, 3'd5, 8'd1, 1'b1, 4'd0, 4'd0);
        idle(10);

        // Start and stop together on ch1's terminal cycle.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_run[1] && m_next[1] == m_cyc + 2) begin
                step(1'b0, 3'd0, 8'd0, 1'b0, 4'b0010, 4'b0010);
                found = 1'b1;
            end else begin
                idle(1);
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL term_search got=0 exp=1");
        end
        idle(10);

        // Restart in the middle of an interval.
        step(1'b0, 3'd0, 8'd0, 1'b0, 4'b0010, 4'd0);
        idle(3);
        step(1'b0, 3'd0, 8'd0, 1'b0, 4'b0010, 4'd0);
        idle(15);

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < N; c++) begin
                rs[c] = ($urandom_range(0, 15) == 0);
                rp[c] = ($urandom_range(0, 31) == 0);
            end
            step(($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), rs, rp);
        end
        idle(10);

        // P=0 periodic on ch3: the tick stays high every cycle.
        step(1'b1, 3'd3, 8'd0, 1'b0, 4'd0, 4'd0);
        step(1'b0, 3'd0, 8'd0, 1'b0, 4'b1000, 4'd0);
        idle(10);

        // Asynchronous reset asserted between clock edges.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_now("async_tick", 32'(tick), 32'd0);
        check_now("async_busy", 32'(busy), 32'(AUTO));
        check_now("async_any", 32'(tick_any), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
